// File: rtl/iserdes_test_scheduler_if.sv
// Control/status bundle between the ISERDES test scheduler and its test-unit harness.
interface iserdes_test_scheduler_if #(
  parameter int NUM_LANES = 10
);
  logic                 I_START;
  logic [NUM_LANES-1:0] I_ERROR;
  logic [NUM_LANES-1:0] O_LANE_RST;
  logic [3:0]           O_LANE_SEL;
  logic                 O_BUSY;
  logic                 O_DONE;
  logic [NUM_LANES-1:0] O_PASS;
  logic [4:0]           O_FAIL_CNT;

  modport master (
    output I_START, I_ERROR,
    input  O_LANE_RST, O_LANE_SEL, O_BUSY, O_DONE, O_PASS, O_FAIL_CNT
  );

  modport slave (
    input  I_START, I_ERROR,
    output O_LANE_RST, O_LANE_SEL, O_BUSY, O_DONE, O_PASS, O_FAIL_CNT
  );
endinterface

// File: rtl/iserdes_test_scheduler.sv
// Sequences ISERDES test lanes one at a time: reset, settle, check, record pass/fail.
// Define ISERDES_SCHED_LOOP_EN to restart a new run automatically after every completed run.
module iserdes_test_scheduler #(
  parameter int NUM_LANES     = 10,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CHECK_CYCLES  = 65536
) (
  input logic                     CLK,
  input logic                     RSTN,
  iserdes_test_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LRST, SETTLE, CHECK, NEXT, DONE} state_t;

  localparam logic [3:0]  LAST_LANE   = 4'(NUM_LANES - 1);
  localparam logic [31:0] RST_LOAD    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] CHECK_LOAD  = 32'(CHECK_CYCLES - 1);

  state_t               state, state_nxt;
  logic [31:0]          timer, timer_nxt;
  logic [3:0]           sel, sel_nxt;
  logic [NUM_LANES-1:0] sticky, sticky_nxt;
  logic [NUM_LANES-1:0] pass, pass_nxt;
  logic [4:0]           fail_cnt, fail_cnt_nxt;
  logic [NUM_LANES-1:0] sel_mask;
  logic [NUM_LANES-1:0] lane_rst;
  logic                 start_req;
  logic                 busy;

  assign sel_mask = NUM_LANES'(1) << sel;
  assign busy     = (state == LRST) || (state == SETTLE) || (state == CHECK) || (state == NEXT);

`ifdef ISERDES_SCHED_LOOP_EN
  assign start_req = bus.I_START || (state == DONE);
`else
  assign start_req = bus.I_START;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      timer    <= '0;
      sel      <= '0;
      sticky   <= '0;
      pass     <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      sel      <= sel_nxt;
      sticky   <= sticky_nxt;
      pass     <= pass_nxt;
      fail_cnt <= fail_cnt_nxt;
    end
  end

  // Each phase loads the timer with its length minus one and leaves when it reaches zero.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    sel_nxt      = sel;
    sticky_nxt   = sticky;
    pass_nxt     = pass;
    fail_cnt_nxt = fail_cnt;
    unique case (state)
      IDLE, DONE: begin
        if (start_req) begin
          state_nxt    = LRST;
          timer_nxt    = RST_LOAD;
          sel_nxt      = '0;
          sticky_nxt   = '0;
          pass_nxt     = '0;
          fail_cnt_nxt = '0;
        end
      end
      LRST: begin
        if (timer == '0) begin
          state_nxt = SETTLE;
          timer_nxt = SETTLE_LOAD;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      SETTLE: begin
        if (timer == '0) begin
          state_nxt = CHECK;
          timer_nxt = CHECK_LOAD;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      CHECK: begin
        if (|(bus.I_ERROR & sel_mask)) begin
          sticky_nxt = sticky | sel_mask;
        end
        if (timer == '0) begin
          state_nxt = NEXT;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      NEXT: begin
        if (|(sticky & sel_mask)) begin
          fail_cnt_nxt = fail_cnt + 5'd1;
        end else begin
          pass_nxt = pass | sel_mask;
        end
        if (sel == LAST_LANE) begin
          state_nxt = DONE;
        end else begin
          state_nxt = LRST;
          sel_nxt   = sel + 4'd1;
          timer_nxt = RST_LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the lane under test is released from reset, and only once its reset phase ends.
  always_comb begin
    lane_rst = '1;
    if (busy && (state != LRST)) begin
      lane_rst = ~sel_mask;
    end
  end

  assign bus.O_LANE_RST = lane_rst;
  assign bus.O_LANE_SEL = sel;
  assign bus.O_BUSY     = busy;
  assign bus.O_DONE     = (state == DONE);
  assign bus.O_PASS     = pass;
  assign bus.O_FAIL_CNT = fail_cnt;

endmodule

// File: tb/tb_iserdes_test_scheduler.sv
// Testbench for iserdes_test_scheduler with a run-level reference model.
module tb_iserdes_test_scheduler;

  localparam int NL     = 3;
  localparam int RC     = 2;
  localparam int SC     = 4;
  localparam int CC     = 8;
  localparam int LANE_T = RC + SC + CC + 1;
  localparam int RUN_T  = NL * LANE_T;
`ifdef ISERDES_SCHED_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  iserdes_test_scheduler_if #(.NUM_LANES(NL)) bus ();

  iserdes_test_scheduler #(
    .NUM_LANES    (NL),
    .RST_CYCLES   (RC),
    .SETTLE_CYCLES(SC),
    .CHECK_CYCLES (CC)
  ) dut (
    .CLK (clk),
    .RSTN(rstN),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position inside the current run, in cycles since the start was accepted.
  bit          mRunning;
  bit          mDoneHeld;
  int          mK;
  bit [NL-1:0] mErr;
  bit [NL-1:0] mPass;
  int          mFail;
  int          runCount = 0;
  int          mode = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mRunning  = 1'b0;
    mDoneHeld = 1'b0;
    mK        = 0;
    mErr      = '0;
    mPass     = '0;
    mFail     = 0;
  endtask

  task automatic modelStep();
    int lane;
    int ph;
    if (!mRunning) begin
      if (bus.I_START || (LOOP_EN && mDoneHeld)) begin
        modelReset();
        mRunning = 1'b1;
        mode     = (runCount < 6) ? runCount : int'($urandom_range(0, 5));
        runCount++;
      end
    end else begin
      lane = mK / LANE_T;
      ph   = mK % LANE_T;
      if (ph >= RC + SC && ph < LANE_T - 1 && bus.I_ERROR[lane]) mErr[lane] = 1'b1;
      if (ph == LANE_T - 1) begin
        mPass[lane] = !mErr[lane];
        if (mErr[lane]) mFail++;
      end
      mK++;
      if (mK == RUN_T) begin
        mRunning  = 1'b0;
        mDoneHeld = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    int lane;
    int ph;
    logic [NL-1:0] expRst;
    lane = mK / LANE_T;
    ph   = mK % LANE_T;
    checkOutput("busy", 32'(bus.O_BUSY), 32'(mRunning));
    checkOutput("done", 32'(bus.O_DONE), 32'(!mRunning && mDoneHeld));
    checkOutput("pass", 32'(bus.O_PASS), 32'(mPass));
    checkOutput("failcnt", 32'(bus.O_FAIL_CNT), 32'(mFail));
    expRst = '1;
    if (mRunning) begin
      checkOutput("sel", 32'(bus.O_LANE_SEL), 32'(lane));
      if (ph >= RC) expRst[lane] = 1'b0;
    end
    checkOutput("lanerst", 32'(bus.O_LANE_RST), 32'(expRst));
  endtask

  task automatic applyStimulus(input bit allowStart);
    logic [NL-1:0] e;
    int lane;
    int ph;
    lane = mK / LANE_T;
    ph   = mK % LANE_T;
    e    = '0;
    if (mRunning) begin
      case (mode)
        1: for (int i = 0; i < NL; i++) e[i] = ($urandom_range(0, 5) == 0);
        2: e = '1;
        3: if (mK == LANE_T + RC + SC + CC - 1) e[1] = 1'b1;
        4: if (lane == 1 && ph >= RC && ph < RC + SC) e[1] = 1'b1;
        5: if (lane == 0) e[2] = 1'b1;
        default: e = '0;
      endcase
    end else begin
      e = NL'($urandom);
    end
    bus.I_ERROR = e;
    bus.I_START = allowStart && ($urandom_range(0, 3) == 0);
  endtask

  task automatic cycle(input bit allowStart);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
    applyStimulus(allowStart);
  endtask

  initial begin
    int budget;
    bus.I_START = 1'b0;
    bus.I_ERROR = '0;
    modelReset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkAll();
    checkOutput("selReset", 32'(bus.O_LANE_SEL), 32'd0);
    rstN = 1'b1;

    for (int c = 0; c < 1500; c++) cycle(1'b1);

    // Drive into lane 1's check window, then pull reset asynchronously.
    budget = 0;
    while (!(mRunning && mK == LANE_T + RC + SC + 3) && budget < 500) begin
      cycle(1'b1);
      budget++;
    end
    checkOutput("reachLane1Check", 32'(budget < 500), 32'd1);
    #2 rstN = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("selAsyncReset", 32'(bus.O_LANE_SEL), 32'd0);
    bus.I_START = 1'b0;
    @(negedge clk);
    checkAll();
    rstN = 1'b1;

    for (int c = 0; c < 10; c++) cycle(1'b0);

    bus.I_START = 1'b1;
    cycle(1'b0);
    for (int c = 0; c < RUN_T + 10; c++) cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iserdes_test_scheduler.md
ISERDES_TEST_SCHEDULER -- requirements
Module: iserdes_test_scheduler

Interface
REQ-001 SHALL have parameter NUM_LANES, default 10: number of ISERDES test lanes sequenced (1..16).
REQ-002 SHALL have parameter RST_CYCLES, default 16: cycles the selected lane is held in reset (>=1).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1024: cycles after lane reset during which lane errors are ignored (>=1).
REQ-004 SHALL have parameter CHECK_CYCLES, default 65536: cycles during which lane errors are sampled (>=1).
REQ-005 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port RSTN  input  1  asynchronous active-low reset.
REQ-007 SHALL have port I_START  input  1  run request, sampled each cycle.
REQ-008 SHALL have port I_ERROR  input  NUM_LANES  per-lane error flags from the test units.
REQ-009 SHALL have port O_LANE_RST  output  NUM_LANES  per-lane active-high reset to the test units.
REQ-010 SHALL have port O_LANE_SEL  output  4  index of the lane currently under test.
REQ-011 SHALL have port O_BUSY  output  1  high while a run is in progress.
REQ-012 SHALL have port O_DONE  output  1  high while results of a completed run are held.
REQ-013 SHALL have port O_PASS  output  NUM_LANES  per-lane pass flag of the last completed run.
REQ-014 SHALL have port O_FAIL_CNT  output  5  number of failed lanes in the last completed run.

Function
REQ-015 SHALL implement states IDLE, LRST, SETTLE, CHECK, NEXT, DONE with a single down-counting timer of 32 bits.
REQ-016 IDLE or DONE with I_START=1: next cycle enters LRST, lane index=0, O_BUSY=1, O_DONE=0, O_PASS and O_FAIL_CNT cleared to 0, per-lane sticky error cleared.
REQ-017 I_START SHALL be ignored in LRST, SETTLE, CHECK, NEXT (no restart, no abort).
REQ-018 LRST: O_LANE_RST[sel]=1 for exactly RST_CYCLES cycles, then SETTLE.
REQ-019 SETTLE: O_LANE_RST[sel]=0, I_ERROR ignored, exactly SETTLE_CYCLES cycles, then CHECK.
REQ-020 CHECK: exactly CHECK_CYCLES cycles; any cycle with I_ERROR[sel]=1 (including first and last) sets sticky error for sel.
REQ-021 NEXT (1 cycle): O_PASS[sel] <= ~sticky; O_FAIL_CNT incremented if sticky; if sel==NUM_LANES-1 go DONE, else sel+1 and LRST.
REQ-022 Per-lane run time SHALL be RST_CYCLES+SETTLE_CYCLES+CHECK_CYCLES+1 cycles.
REQ-023 Non-selected lanes SHALL have O_LANE_RST=1 whenever O_BUSY=1; all O_LANE_RST bits SHALL be 1 in IDLE and DONE.
REQ-024 I_ERROR of non-selected lanes SHALL be ignored at all times.
REQ-025 DONE: O_DONE=1, O_BUSY=0, O_PASS/O_FAIL_CNT held stable until next accepted start.
REQ-026 O_PASS bits of lanes not yet evaluated in a run SHALL read 0.

Reset
REQ-027 RSTN=0 SHALL asynchronously force IDLE, O_LANE_RST all 1s, O_LANE_SEL=0, O_BUSY=0, O_DONE=0, O_PASS=0, O_FAIL_CNT=0, timer=0, sticky errors=0.
REQ-028 RSTN asserted mid-run SHALL discard all partial results; after deassertion the block waits in IDLE for I_START.

Configuration
REQ-029 Macro ISERDES_SCHED_LOOP_EN defined: DONE SHALL automatically begin a new run on the next cycle (as if I_START=1), O_PASS/O_FAIL_CNT of the completed run then cleared per REQ-016, O_DONE high for exactly one cycle.
REQ-030 Macro ISERDES_SCHED_LOOP_EN undefined: DONE SHALL persist until I_START=1 or reset.

Verification (NUM_LANES=3, RST_CYCLES=2, SETTLE_CYCLES=4, CHECK_CYCLES=8, loop macro undefined unless stated)
REQ-031 Reset then I_START pulse, I_ERROR=0 -> O_BUSY high 45 cycles, then O_DONE=1, O_PASS=3'b111, O_FAIL_CNT=0.
REQ-032 I_ERROR[1]=1 only during lane 1 SETTLE -> O_PASS=3'b111, O_FAIL_CNT=0; one-cycle I_ERROR[1] on last CHECK cycle -> O_PASS=3'b101, O_FAIL_CNT=1.
REQ-033 I_ERROR[2]=1 constantly while lane 0 tested -> O_PASS=3'b111; I_ERROR=3'b111 always -> O_PASS=3'b000, O_FAIL_CNT=3.
REQ-034 I_START pulses at cycle 10 of run -> no restart, DONE still reached at cycle 45; O_LANE_RST equals ~(1<<sel) during LRST-excluded phases and 3'b111 in IDLE/DONE.
REQ-035 RSTN low during lane 1 CHECK -> all outputs at reset values immediately (asynchronously); no run resumes without I_START.
REQ-036 ISERDES_SCHED_LOOP_EN defined -> O_DONE pulses one cycle every 46 cycles, O_BUSY low only in that cycle.
